// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial framing receiver. Detects a start bit, shifts WIDTH
// data bits LSB-first, optionally checks even parity and the stop bit, and
// hands completed words to a consumer over a valid/ready handshake.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             shift_en,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_par_flag;
    logic [WIDTH-1:0] r_po;
    logic             r_po_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_last_bit;
    logic             w_word_ok;
    logic             w_frame_bad;

    // Next-state decode and stop-edge classification of the current frame.
    always_comb begin
        w_next      = r_state;
        w_last_bit  = (r_cnt == CNT_W'(WIDTH - 1));
        w_word_ok   = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!si) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_bit) begin
                    w_next = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_next = S_STOP;
            end
            S_STOP: begin
                if (si) begin
                    w_next = S_IDLE;
                    if (r_par_flag) begin
                        w_frame_bad = 1'b1;
                    end else begin
                        w_word_ok = 1'b1;
                    end
                end else begin
                    // Line still low: wait for idle so it is not read as a start bit.
                    w_frame_bad = 1'b1;
                    w_next      = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (si) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shift register, bit counter and parity flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_par_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt      <= '0;
                    r_par_flag <= 1'b0;
                end
                S_DATA: begin
                    r_sr <= {si, r_sr[WIDTH-1:1]};
                    if (!w_last_bit) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    r_par_flag <= (^r_sr) ^ si;
                end
                default: begin
                end
            endcase
        end
    end

    // Output holding register, handshake and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_po        <= '0;
            r_po_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= 1'b0;
            if (w_word_ok) begin
                if (!r_po_valid || po_ready) begin
                    r_po       <= r_sr;
                    r_po_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_po_valid && po_ready) begin
                r_po_valid <= 1'b0;
            end
        end
    end

    assign po        = r_po;
    assign po_valid  = r_po_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign shift_en  = (r_state == S_DATA);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: one instance without parity, one with parity,
// driven by the same serial line and checked against a frame-offset model.
module tb_sipo_frame_ctrl;

    logic clk;
    logic rst;
    logic si;
    logic po_ready;

    logic [3:0] po0, po1;
    logic po_valid0, po_valid1, shift_en0, shift_en1;
    logic busy0, busy1, frame_err0, frame_err1, overrun0, overrun1;

    int checks = 0;
    int errors = 0;
    int sen_cnt = 0;

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .si(si), .po(po0), .po_valid(po_valid0),
        .po_ready(po_ready), .shift_en(shift_en0), .busy(busy0),
        .frame_err(frame_err0), .overrun(overrun0)
    );

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .si(si), .po(po1), .po_valid(po_valid1),
        .po_ready(po_ready), .shift_en(shift_en1), .busy(busy1),
        .frame_err(frame_err1), .overrun(overrun1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: frame position counted in edges since the start bit (-1 = idle).
    int         m_phase[2];
    bit         m_wait[2];
    logic [3:0] m_bits[2];
    bit         m_pbit[2];
    logic [3:0] m_po[2];
    bit         m_valid[2];
    bit         m_ferr[2];
    bit         m_ovr[2];
    bit         m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit par);
        bit done;
        bit even;
        done = 1'b0;
        m_ferr[k] = 1'b0;
        m_ovr[k] = 1'b0;
        if (m_wait[k]) begin
            if (si) m_wait[k] = 1'b0;
        end else if (m_phase[k] < 0) begin
            if (!si) begin
                m_phase[k] = 0;
                m_bits[k] = 4'h0;
                m_pbit[k] = 1'b0;
            end
        end else begin
            m_phase[k] = m_phase[k] + 1;
            if (m_phase[k] <= 4) begin
                m_bits[k] = m_bits[k] | (4'(si) << (m_phase[k] - 1));
            end else if (par && m_phase[k] == 5) begin
                m_pbit[k] = si;
            end else begin
                m_phase[k] = -1;
                even = ((($countones(m_bits[k]) + int'(m_pbit[k])) % 2) == 0);
                if (!si) begin
                    m_wait[k] = 1'b1;
                    m_ferr[k] = 1'b1;
                end else if (par && !even) begin
                    m_ferr[k] = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
        end
        if (done) begin
            if (!m_valid[k] || po_ready) begin
                m_po[k] = m_bits[k];
                m_valid[k] = 1'b1;
            end else begin
                m_ovr[k] = 1'b1;
            end
        end else if (m_valid[k] && po_ready) begin
            m_valid[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        m_live = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] = -1;
                m_wait[k] = 1'b0;
                m_bits[k] = 4'h0;
                m_pbit[k] = 1'b0;
                m_po[k] = 4'h0;
                m_valid[k] = 1'b0;
                m_ferr[k] = 1'b0;
                m_ovr[k] = 1'b0;
            end else begin
                model_step(k, (k == 1));
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        logic [3:0] a_po;
        logic a_v, a_se, a_b, a_fe, a_ov;
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                a_po = (k == 0) ? po0 : po1;
                a_v  = (k == 0) ? po_valid0 : po_valid1;
                a_se = (k == 0) ? shift_en0 : shift_en1;
                a_b  = (k == 0) ? busy0 : busy1;
                a_fe = (k == 0) ? frame_err0 : frame_err1;
                a_ov = (k == 0) ? overrun0 : overrun1;
                chk($sformatf("dut%0d po", k), 32'(a_po), 32'(m_po[k]));
                chk($sformatf("dut%0d po_valid", k), 32'(a_v), 32'(m_valid[k]));
                chk($sformatf("dut%0d shift_en", k), 32'(a_se),
                    32'(m_phase[k] >= 0 && m_phase[k] < 4));
                chk($sformatf("dut%0d busy", k), 32'(a_b),
                    32'(m_phase[k] >= 0 || m_wait[k]));
                chk($sformatf("dut%0d frame_err", k), 32'(a_fe), 32'(m_ferr[k]));
                chk($sformatf("dut%0d overrun", k), 32'(a_ov), 32'(m_ovr[k]));
            end
            if (shift_en0) sen_cnt++;
        end
    end

    task automatic bit_in(input logic b);
        si = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bit_in(1'b1);
    endtask

    // par < 0: no parity bit sent; otherwise par is the parity bit value.
    task automatic send(input logic [3:0] w, input int par, input logic stop, input bit rdy_stop);
        logic [3:0] wv;
        wv = w;
        bit_in(1'b0);
        for (int i = 0; i < 4; i++) bit_in(wv[i]);
        if (par >= 0) bit_in(par[0]);
        if (rdy_stop) po_ready = 1'b1;
        bit_in(stop);
        if (rdy_stop) po_ready = 1'b0;
    endtask

    task automatic consume;
        po_ready = 1'b1;
        @(posedge clk);
        #1;
        po_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        si = 1'b1;
        po_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset po", 32'(po0), 32'h0);
        chk("reset po_valid", 32'(po_valid0), 32'h0);
        chk("reset busy", 32'(busy0), 32'h0);
        idle(2);

        // 1: basic frame 4'hD
        sen_cnt = 0;
        send(4'hD, -1, 1'b1, 1'b0);
        chk("t1 po", 32'(po0), 32'hD);
        chk("t1 po_valid", 32'(po_valid0), 32'h1);
        chk("t1 shift_en cycles", 32'(sen_cnt), 32'd4);
        consume();
        chk("t1 consumed", 32'(po_valid0), 32'h0);
        idle(2);

        // 2: bad stop bit, line held low
        send(4'h5, -1, 1'b0, 1'b0);
        chk("t2 frame_err", 32'(frame_err0), 32'h1);
        chk("t2 po_valid", 32'(po_valid0), 32'h0);
        repeat (3) bit_in(1'b0);
        chk("t2 busy low", 32'(busy0), 32'h1);
        chk("t2 frame_err once", 32'(frame_err0), 32'h0);
        bit_in(1'b1);
        chk("t2 busy idle", 32'(busy0), 32'h0);
        idle(2);
        consume();

        // 3: overrun with consumer stalled
        send(4'hD, -1, 1'b1, 1'b0);
        send(4'h3, -1, 1'b1, 1'b0);
        chk("t3 overrun", 32'(overrun0), 32'h1);
        chk("t3 po held", 32'(po0), 32'hD);
        consume();
        chk("t3 po_valid drop", 32'(po_valid0), 32'h0);
        idle(2);

        // 4: ready coincides with completion
        send(4'hD, -1, 1'b1, 1'b0);
        send(4'h3, -1, 1'b1, 1'b1);
        chk("t4 no overrun", 32'(overrun0), 32'h0);
        chk("t4 po", 32'(po0), 32'h3);
        chk("t4 po_valid", 32'(po_valid0), 32'h1);
        idle(1);
        chk("t4 po_valid held", 32'(po_valid0), 32'h1);
        consume();
        idle(2);

        // 5: reset mid-frame
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5 busy", 32'(busy0), 32'h0);
        chk("t5 po_valid", 32'(po_valid0), 32'h0);
        chk("t5 frame_err", 32'(frame_err0), 32'h0);
        idle(1);
        send(4'hA, -1, 1'b1, 1'b0);
        chk("t5 po", 32'(po0), 32'hA);
        idle(3);
        consume();
        idle(2);

        // 6: parity instance, odd then even total
        send(4'hD, 0, 1'b1, 1'b0);
        chk("t6 parity frame_err", 32'(frame_err1), 32'h1);
        chk("t6 parity po_valid", 32'(po_valid1), 32'h0);
        idle(2);
        send(4'hD, 1, 1'b1, 1'b0);
        chk("t6 parity po", 32'(po1), 32'hD);
        chk("t6 parity po_valid ok", 32'(po_valid1), 32'h1);
        chk("t6 parity no err", 32'(frame_err1), 32'h0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
